modinv_div_core: RTL and testbench

Modular-division core for the ECC datapath: computes c = a · b⁻¹ mod m for N-bit operands with a binary extended-Euclidean iteration, one elementary step per clock. With a = 1 it is a plain modular inverter. Field-level blocks (point add/double) use it for the projective-to-affine conversion and slope division.

---
 rtl/modinv_div_core_pkg.sv | 13 +
 rtl/modinv_div_core_modsub_or_half.sv | 25 ++
 rtl/modinv_div_core.sv | 154 +++++++++++++++
 tb/tb_modinv_div_core.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/modinv_div_core_pkg.sv
// Shared definitions for the modular-division core: default operand width and
// the controller state encoding.
package modinv_div_core_pkg;

  localparam int unsigned N_DEFAULT = 256;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/modinv_div_core_modsub_or_half.sv
// Combinational coefficient update: either (x - y) mod M or x / 2 mod M, using
// N+1-bit intermediates so neither the carry nor the borrow is lost.
module modsub_or_half #(
  parameter int unsigned N = 256
) (
  input  logic [N-1:0] x_i,
  input  logic [N-1:0] y_i,
  input  logic [N-1:0] mod_i,
  input  logic         half_i,
  output logic [N-1:0] r_o
);

  logic [N:0] sum_half;
  logic [N:0] diff;
  logic [N:0] diff_fix;

  always_comb begin
    // Odd x: add the odd modulus first so the sum is even and halves exactly.
    sum_half = {1'b0, x_i} + (x_i[0] ? {1'b0, mod_i} : '0);
    diff     = {1'b0, x_i} - {1'b0, y_i};
    diff_fix = diff + (diff[N] ? {1'b0, mod_i} : '0);
    r_o      = half_i ? sum_half[N:1] : diff_fix[N-1:0];
  end

endmodule

// File: rtl/modinv_div_core.sv
// Modular division c = a * b^-1 mod m via binary extended Euclid, one step per
// clock. Invariants: x1*b == a*u and x2*b == a*v (mod M).
module modinv_div_core
  import modinv_div_core_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] b,
  input  logic [N-1:0] a,
  input  logic [N-1:0] m,
  output logic [N-1:0] c,
  output logic         ready,
  output logic         busy,
  output logic         ready0,
  output logic [1:0]   dbg_state_o
);

  localparam int unsigned    CW  = $clog2(4 * N) + 1;
  localparam logic [CW-1:0]  CAP = CW'(4 * N);
  localparam logic [N-1:0]   ONE = {{(N-1){1'b0}}, 1'b1};

  state_e        state_q, state_d;
  logic [N-1:0]  u_q, u_d, v_q, v_d;
  logic [N-1:0]  x1_q, x1_d, x2_q, x2_d;
  logic [N-1:0]  m_q, m_d, c_q, c_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ready_q, ready_d, busy_q, busy_d, ready0_q, ready0_d;

  logic [N-1:0]  x1_nx, x2_nx, res;
  logic          fin;

  modsub_or_half #(.N(N)) u_upd_x1 (
    .x_i    (x1_q),
    .y_i    (x2_q),
    .mod_i  (m_q),
    .half_i (~u_q[0]),
    .r_o    (x1_nx)
  );

  modsub_or_half #(.N(N)) u_upd_x2 (
    .x_i    (x2_q),
    .y_i    (x1_q),
    .mod_i  (m_q),
    .half_i (~v_q[0]),
    .r_o    (x2_nx)
  );

  always_comb begin
    state_d  = state_q;
    u_d      = u_q;
    v_d      = v_q;
    x1_d     = x1_q;
    x2_d     = x2_q;
    m_d      = m_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    ready_d  = ready_q;
    busy_d   = busy_q;
    ready0_d = 1'b0;
    fin      = 1'b1;
    res      = '0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_CALC;
          u_d     = b;
          v_d     = m;
          x1_d    = a;
          x2_d    = '0;
          m_d     = m;
          c_d     = '0;
          cnt_d   = '0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      ST_CALC: begin
        // Termination is tested on the current u/v before any step is taken.
        if (u_q == ONE) begin
          res = x1_q;
        end else if (v_q == ONE) begin
          res = x2_q;
        end else if (u_q == '0 || v_q == '0 || cnt_q == CAP) begin
          res = '0;
        end else begin
          fin = 1'b0;
        end

        if (fin) begin
          state_d  = ST_DONE;
          c_d      = res;
          ready_d  = 1'b1;
          busy_d   = 1'b0;
          ready0_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (!u_q[0]) begin
            u_d  = u_q >> 1;
            x1_d = x1_nx;
          end else if (!v_q[0]) begin
            v_d  = v_q >> 1;
            x2_d = x2_nx;
          end else if (u_q >= v_q) begin
            u_d  = u_q - v_q;
            x1_d = x1_nx;
          end else begin
            v_d  = v_q - u_q;
            x2_d = x2_nx;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      u_q      <= '0;
      v_q      <= '0;
      x1_q     <= '0;
      x2_q     <= '0;
      m_q      <= '0;
      c_q      <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      ready0_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      u_q      <= u_d;
      v_q      <= v_d;
      x1_q     <= x1_d;
      x2_q     <= x2_d;
      m_q      <= m_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      ready0_q <= ready0_d;
    end
  end

  assign c           = c_q;
  assign ready       = ready_q;
  assign busy        = busy_q;
  assign ready0      = ready0_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_modinv_div_core.sv
// Directed and reference-checked bench for modinv_div_core: inputs are driven and
// outputs sampled on the falling clock edge.
module tb_modinv_div_core;
  import modinv_div_core_pkg::*;

  localparam int W = 256;
  localparam logic [W-1:0] P =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] b = '0, a = '0, m = '0;
  logic [W-1:0] c;
  logic         ready, busy, ready0;
  logic [1:0]   dbg_state;

  int           n_cmp = 0;
  int           n_err = 0;
  int           r0_cnt = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] res, rb, half_p;

  modinv_div_core #(.N(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .b           (b),
    .a           (a),
    .m           (m),
    .c           (c),
    .ready       (ready),
    .busy        (busy),
    .ready0      (ready0),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) if (ready0) r0_cnt++;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // checking
  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mulmod(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic [W-1:0] md);
    logic [W:0] r;
    r = '0;
    for (int i = W - 1; i >= 0; i--) begin
      r = r << 1;
      if (r >= {1'b0, md}) r = r - {1'b0, md};
      if (y[i]) begin
        r = r + {1'b0, x};
        if (r >= {1'b0, md}) r = r - {1'b0, md};
      end
    end
    return r[W-1:0];
  endfunction

  // drivers
  task automatic scramble_inputs();
    b = {$urandom, $urandom};
    a = {$urandom, $urandom};
    m = {$urandom, $urandom};
  endtask

  task automatic start_op(input logic [W-1:0] bv, input logic [W-1:0] av, input logic [W-1:0] mv);
    @(negedge clk);
    start = 1'b1;
    b = bv;
    a = av;
    m = mv;
    @(negedge clk);
    start = 1'b0;
    scramble_inputs();
  endtask

  task automatic wait_done(input string tag, output logic [W-1:0] r);
    for (int k = 0; k < 3000; k++) begin
      if (ready) break;
      @(negedge clk);
    end
    check_eq({tag, "_ready"}, ready, 1'b1);
    check_eq({tag, "_busy_low"}, busy, 1'b0);
    check_eq({tag, "_ready0_rise"}, ready0, 1'b1);
    r = c;
    @(negedge clk);
    check_eq({tag, "_ready0_fall"}, ready0, 1'b0);
    check_eq({tag, "_ready0_once"}, r0_cnt, 1);
    check_eq({tag, "_c_hold"}, c, r);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] bv, input logic [W-1:0] av,
                        input logic [W-1:0] mv, output logic [W-1:0] r);
    r0_cnt = 0;
    start_op(bv, av, mv);
    check_eq({tag, "_busy"}, busy, 1'b1);
    wait_done(tag, r);
  endtask

  task automatic run_dir(input string tag, input logic [W-1:0] bv, input logic [W-1:0] av,
                         input logic [W-1:0] mv, input logic [W-1:0] ev);
    logic [W-1:0] r;
    exp_q.push_back(ev);
    run_op(tag, bv, av, mv, r);
    check_eq(tag, r, exp_q.pop_front());
  endtask

  initial begin
    half_p = (P >> 1) + 1;
    repeat (3) @(negedge clk);
    check_eq("rst_c", c, '0);
    check_eq("rst_ready", ready, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_ready0", ready0, 1'b0);
    check_eq("rst_state", dbg_state, ST_IDLE);
    rst_n = 1'b1;
    @(negedge clk);

    run_dir("inv367", 256'hbe, 256'd1, 256'd367, 256'he2);
    run_dir("div7", 256'd3, 256'd5, 256'd7, 256'd4);
    run_dir("div7b", 256'd1, 256'd6, 256'd7, 256'd6);
    run_dir("half_p", 256'd2, 256'd1, P, half_p);

    for (int i = 0; i < 100; i++) begin
      for (int j = 0; j < 8; j++) rb[j*32 +: 32] = $urandom;
      if (rb >= P) rb = rb - P;
      if (rb == '0) rb = 256'd1;
      run_op("rand", rb, 256'd1, P, res);
      check_eq("rand_inv", mulmod(res, rb, P), 256'd1);
    end

    run_dir("gcd3", 256'd6, 256'd1, 256'd9, 256'd0);
    run_dir("b_zero", 256'd0, 256'd1, 256'd7, 256'd0);

    // start while busy must not disturb the running operation
    r0_cnt = 0;
    start_op(256'hbe, 256'd1, 256'd367);
    repeat (2) @(negedge clk);
    start = 1'b1;
    b = 256'd5;
    a = 256'd3;
    m = 256'd11;
    @(negedge clk);
    start = 1'b0;
    check_eq("mid_start_busy", busy, 1'b1);
    wait_done("mid_start", res);
    check_eq("mid_start_c", res, 256'he2);

    // asynchronous abort mid-calculation
    for (int j = 0; j < 8; j++) rb[j*32 +: 32] = $urandom;
    if (rb >= P) rb = rb - P;
    if (rb == '0) rb = 256'd3;
    start_op(rb, 256'd1, P);
    repeat (20) @(negedge clk);
    check_eq("abort_busy_pre", busy, 1'b1);
    r0_cnt = 0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_ready", ready, 1'b0);
    check_eq("abort_c", c, '0);
    check_eq("abort_state", dbg_state, ST_IDLE);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("abort_no_ready0", r0_cnt, 0);
    check_eq("abort_ready_after", ready, 1'b0);

    // restart directly from DONE
    run_dir("pre_done", 256'd3, 256'd5, 256'd7, 256'd4);
    r0_cnt = 0;
    start = 1'b1;
    b = 256'hbe;
    a = 256'd1;
    m = 256'd367;
    @(negedge clk);
    start = 1'b0;
    scramble_inputs();
    check_eq("done_restart_ready", ready, 1'b0);
    check_eq("done_restart_busy", busy, 1'b1);
    wait_done("done_restart", res);
    check_eq("done_restart_c", res, 256'he2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
